div_sign_ctrl: RTL and testbench
================================

DIV_SIGN_CTRL -- requirements
Module: div_sign_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter CORE_MAX_CYC, default 64: upper bound on core latency; bench use only.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-007 SHALL have port req_signed, input, 1 bit: operands are two's complement.
REQ-008 SHALL have ports req_dividend and req_divisor, input, WIDTH bits each: operands.
REQ-009 SHALL have port core_start, output, 1 bit: one-cycle launch pulse to the unsigned divider core.
REQ-010 SHALL have ports core_dividend and core_divisor, output, WIDTH bits each: unsigned magnitudes, held stable from core_start until core_done.
REQ-011 SHALL have port core_done, input, 1 bit: core results valid this cycle.
REQ-012 SHALL have ports core_quotient and core_remainder, input, WIDTH bits each: unsigned core results.
REQ-013 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-014 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-015 SHALL have ports rsp_quotient and rsp_remainder, output, WIDTH bits each: final results.
REQ-016 SHALL have ports rsp_div0 and rsp_ovf, output, 1 bit each: divide-by-zero flag and signed-overflow flag.

Function
REQ-017 SHALL implement the FSM IDLE, LAUNCH, WAIT, FIX, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE, and SHALL accept a request on req_valid&&req_ready.
REQ-019 SHALL, when the accepted divisor is 0, go directly to RESP with quotient all-ones, remainder = dividend and rsp_div0=1, without starting the core.
REQ-020 SHALL, for a signed request with dividend=MIN and divisor=-1, go directly to RESP with quotient=MIN, remainder=0 and rsp_ovf=1, without starting the core.
REQ-021 SHALL otherwise register the magnitudes |dividend| and |divisor| (plain values if unsigned) and enter LAUNCH.
REQ-022 SHALL assert core_start for exactly one cycle in LAUNCH, then enter WAIT.
REQ-023 SHALL, in WAIT, capture core results on core_done and enter FIX; core_done in any other state SHALL be ignored.
REQ-024 SHALL, in FIX, negate the quotient if the operand signs differ and negate the remainder if the dividend is negative (signed requests only), then enter RESP.
REQ-025 SHALL hold rsp_valid and all rsp_* outputs stable in RESP until rsp_ready, then return to IDLE.
REQ-026 SHALL meet this latency: acceptance at edge T puts core_start high in cycle T+1; core_done in cycle D gives rsp_valid from cycle D+2; a short-circuit request gives rsp_valid in cycle T+1.
REQ-027 SHALL deassert rsp_div0 and rsp_ovf on normal results, and SHALL never assert both.
REQ-028 SHALL keep all arithmetic WIDTH bits wide, with negation as two's complement modulo 2^WIDTH.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE and all outputs to 0, including req_ready.
REQ-030 SHALL, on reset mid-operation, abandon the transaction: no rsp_valid, and a subsequent stray core_done is ignored.
REQ-031 SHALL raise req_ready in the first cycle after rst_n rises.

Configuration
REQ-032 SHALL, with macro DIV_SIGN_CTRL_SIGNED_EN defined, implement signed handling per REQ-020/021/024.
REQ-033 SHALL, with DIV_SIGN_CTRL_SIGNED_EN undefined, ignore req_signed, tie rsp_ovf to 0, and omit the abs/negate logic (all requests unsigned).

Structure
REQ-034 SHALL place the FSM state enum, the WIDTH default and the div0 result constants in shared package div_pkg.
REQ-035 SHALL implement abs/negate in sub-module div_abs_neg, instantiated for the operand and result paths.

Verification
REQ-036 SHALL test: unsigned 100/7 with a 33-cycle core model -> quotient 14, remainder 2, flags 0, rsp_valid at D+2.
REQ-037 SHALL test: signed -100/7 -> quotient -14 (0xFFFFFFF2), remainder -2 (0xFFFFFFFE).
REQ-038 SHALL test: divisor 0, dividend 0x1234 -> quotient 0xFFFFFFFF, remainder 0x1234, rsp_div0=1, no core_start, rsp_valid at T+1.
REQ-039 SHALL test: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, rsp_ovf=1.
REQ-040 SHALL test: rsp_ready held low for 10 cycles -> rsp_* stable and req_ready=0 throughout.
REQ-041 SHALL test: rst_n pulsed low during WAIT, then core_done -> no rsp_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the signed/unsigned divider front-end.
//
// Contents:
//   WIDTH_DEF     - default operand/result width
//   state_t       - controller FSM states
//   DIV0_QUOT_BIT - fill bit for the divide-by-zero quotient (all ones)
package div_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_FIX,
        ST_RESP
    } state_t;

    // A zero divisor returns a quotient of all ones and the dividend as the remainder.
    localparam logic DIV0_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negation, modulo 2^WIDTH.
// Used as abs() on the operand path and as sign restore on the result path.
//
// Ports:
//   value  - input word
//   negate - 1: result = -value, 0: result = value
//   result - output word
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign result = negate ? (~value + ONE) : value;

endmodule

// File: rtl/div_sign_ctrl.sv
// Sign-handling controller around an unsigned multi-cycle divider core.
// Short-circuits divide-by-zero and signed MIN/-1, otherwise feeds operand
// magnitudes to the core and restores result signs afterwards.
//
// Optional feature: DIV_SIGN_CTRL_SIGNED_EN enables two's-complement handling.
// Without it req_signed is ignored, rsp_ovf is tied low and every request is
// treated as unsigned.
//
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   req_valid/req_ready         - request handshake
//   req_signed                  - operands are two's complement
//   req_dividend/req_divisor    - operands
//   core_start                  - one-cycle launch pulse to the core
//   core_dividend/core_divisor  - magnitudes, stable from launch until done
//   core_done                   - core results valid this cycle
//   core_quotient/core_remainder- unsigned core results
//   rsp_valid/rsp_ready         - response handshake
//   rsp_quotient/rsp_remainder  - final results
//   rsp_div0/rsp_ovf            - divide-by-zero / signed-overflow flags
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | ready for a request
// ST_LAUNCH | pulse core_start
// ST_WAIT   | wait for core_done, capture raw results
// ST_FIX    | restore result signs
// ST_RESP   | hold response until rsp_ready
module div_sign_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int CORE_MAX_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    output logic             core_start,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_remainder,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_div0,
    output logic             rsp_ovf
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    if (CORE_MAX_CYC < 1) begin : g_bad_cfg
        $error("CORE_MAX_CYC must be at least 1");
    end

    state_t           state, state_nxt;
    logic             accept;
    logic             is_div0;
    logic             is_ovf;
    logic [WIDTH-1:0] mag_dvd, mag_dvs;
    logic [WIDTH-1:0] fix_quot, fix_rem;

    assign is_div0 = (req_divisor == '0);
    assign accept  = req_valid && req_ready;

`ifdef DIV_SIGN_CTRL_SIGNED_EN
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic sgn;
    logic neg_quot, neg_rem, ovf_q;

    assign sgn    = req_signed;
    assign is_ovf = sgn && (req_dividend == MIN_VAL) && (req_divisor == ALL_ONES);

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
        .value  (req_dividend),
        .negate (sgn & req_dividend[WIDTH-1]),
        .result (mag_dvd)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvs (
        .value  (req_divisor),
        .negate (sgn & req_divisor[WIDTH-1]),
        .result (mag_dvs)
    );

    // Result path works in place on the captured core results.
    div_abs_neg #(.WIDTH(WIDTH)) u_neg_quot (
        .value  (rsp_quotient),
        .negate (neg_quot),
        .result (fix_quot)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_neg_rem (
        .value  (rsp_remainder),
        .negate (neg_rem),
        .result (fix_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            ovf_q    <= is_ovf;
            neg_quot <= sgn && (req_dividend[WIDTH-1] ^ req_divisor[WIDTH-1]);
            neg_rem  <= sgn && req_dividend[WIDTH-1];
        end
    end

    assign rsp_ovf = ovf_q;
`else
    logic unused_signed;

    assign unused_signed = req_signed;
    assign is_ovf        = 1'b0;
    assign mag_dvd       = req_dividend;
    assign mag_dvs       = req_divisor;
    assign fix_quot      = rsp_quotient;
    assign fix_rem       = rsp_remainder;
    assign rsp_ovf       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated by rst_n so req_ready reads 0 while reset is held.
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    state_nxt = (is_div0 || is_ovf) ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                core_start = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_dividend <= '0;
            core_divisor  <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div0      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rsp_div0 <= is_div0;
                        if (is_div0) begin
                            rsp_quotient  <= {WIDTH{DIV0_QUOT_BIT}};
                            rsp_remainder <= req_dividend;
                        end else if (is_ovf) begin
                            rsp_quotient  <= MIN_VAL;
                            rsp_remainder <= '0;
                        end else begin
                            core_dividend <= mag_dvd;
                            core_divisor  <= mag_dvs;
                        end
                    end
                end
                ST_WAIT: begin
                    if (core_done) begin
                        rsp_quotient  <= core_quotient;
                        rsp_remainder <= core_remainder;
                    end
                end
                ST_FIX: begin
                    rsp_quotient  <= fix_quot;
                    rsp_remainder <= fix_rem;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sign_ctrl.sv
`timescale 1ns/1ps
module tb_div_sign_ctrl;

    localparam int W        = 32;
    localparam int CORE_MAX = 64;
`ifdef DIV_SIGN_CTRL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_signed;
    logic [W-1:0] req_dividend, req_divisor;
    logic         core_start, core_done;
    logic [W-1:0] core_dividend, core_divisor, core_quotient, core_remainder;
    logic         rsp_valid, rsp_ready, rsp_div0, rsp_ovf;
    logic [W-1:0] rsp_quotient, rsp_remainder;

    div_sign_ctrl #(.WIDTH(W), .CORE_MAX_CYC(CORE_MAX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_signed     (req_signed),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .core_start     (core_start),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_done      (core_done),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_quotient   (rsp_quotient),
        .rsp_remainder  (rsp_remainder),
        .rsp_div0       (rsp_div0),
        .rsp_ovf        (rsp_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic [W-1:0] mag_dvd;
        logic [W-1:0] mag_dvs;
        logic         div0;
        logic         ovf;
        logic         short_cut;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int checks = 0, errors = 0;
    int ncyc = 0, accept_cyc = -100, done_cyc = -100;
    int rsp_count = 0, sent = 0;
    int core_lat = 33, stall = 0, held = 0;
    bit core_busy = 1'b0;
    logic [W-1:0] cm_a, cm_b;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: division defined by the arithmetic rules, not by the controller's steps.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        exp_t e;
        bit sm;
        logic signed [W-1:0] sa, sb;
        sm = s && SIGNED_EN;
        sa = a;
        sb = b;
        e.div0 = 1'b0;
        e.ovf = 1'b0;
        e.short_cut = 1'b0;
        e.mag_dvd = a;
        e.mag_dvs = b;
        if (b == '0) begin
            e.quot = '1;
            e.rem = a;
            e.div0 = 1'b1;
            e.short_cut = 1'b1;
        end else if (sm && a == MINV && b == '1) begin
            e.quot = MINV;
            e.rem = '0;
            e.ovf = 1'b1;
            e.short_cut = 1'b1;
        end else if (sm) begin
            e.quot = sa / sb;
            e.rem = sa % sb;
            e.mag_dvd = (sa < 0) ? -sa : sa;
            e.mag_dvs = (sb < 0) ? -sb : sb;
        end else begin
            e.quot = a / b;
            e.rem = a % b;
        end
        return e;
    endfunction

    // Unsigned divider core model with programmable latency.
    initial begin
        core_done = 1'b0;
        core_quotient = '0;
        core_remainder = '0;
        forever begin
            @(negedge clk);
            if (rst_n && core_start) begin
                core_busy = 1'b1;
                cm_a = core_dividend;
                cm_b = core_divisor;
                repeat (core_lat) @(posedge clk);
                #1;
                core_done = 1'b1;
                core_quotient = (cm_b != 0) ? cm_a / cm_b : '1;
                core_remainder = (cm_b != 0) ? cm_a % cm_b : cm_a;
                @(posedge clk);
                #1;
                core_done = 1'b0;
                core_quotient = $urandom;
                core_remainder = $urandom;
                core_busy = 1'b0;
            end
        end
    end

    // Consumer: accepts each response after 'stall' cycles of rsp_valid.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                if (held >= stall) rsp_ready = 1'b1;
                held++;
            end else begin
                held = 0;
                rsp_ready = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    logic         prev_rst = 1'b0, prev_start = 1'b0, in_rsp = 1'b0, launched = 1'b0;
    logic [W-1:0] h_q, h_r, st_a, st_b;
    logic         h_d0, h_ov;

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            chk("reset_outputs", W'(|{req_ready, rsp_valid, core_start, rsp_div0, rsp_ovf,
                                      rsp_quotient, rsp_remainder, core_dividend, core_divisor}), '0);
            exp_q.delete();
            in_rsp = 1'b0;
            launched = 1'b0;
        end else begin
            if (!prev_rst) chk("ready_after_reset", W'(req_ready), 1);
            if (req_valid && req_ready) accept_cyc = ncyc;
            if (core_start) begin
                if (prev_start) chk("start_one_cycle", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("start_without_request", 1, 0);
                end else begin
                    chk("start_latency", W'(ncyc), W'(accept_cyc + 1));
                    chk("no_start_on_shortcut", W'(exp_q[0].short_cut), 0);
                    chk("core_dividend", core_dividend, exp_q[0].mag_dvd);
                    chk("core_divisor", core_divisor, exp_q[0].mag_dvs);
                end
                st_a = core_dividend;
                st_b = core_divisor;
                launched = 1'b1;
            end
            if (core_done) begin
                done_cyc = ncyc;
                if (launched) begin
                    chk("core_operands_stable", W'({core_dividend, core_divisor} == {st_a, st_b}), 1);
                    launched = 1'b0;
                end
            end
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_rsp", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("quotient", rsp_quotient, cur.quot);
                        chk("remainder", rsp_remainder, cur.rem);
                        chk("div0", W'(rsp_div0), W'(cur.div0));
                        chk("ovf", W'(rsp_ovf), W'(cur.ovf));
                        chk("rsp_latency", W'(ncyc),
                            W'(cur.short_cut ? accept_cyc + 1 : done_cyc + 2));
                    end
                    h_q = rsp_quotient;
                    h_r = rsp_remainder;
                    h_d0 = rsp_div0;
                    h_ov = rsp_ovf;
                    in_rsp = 1'b1;
                end else begin
                    chk("rsp_stable", W'({rsp_quotient, rsp_remainder, rsp_div0, rsp_ovf} ==
                                          {h_q, h_r, h_d0, h_ov}), 1);
                end
                chk("ready_low_in_rsp", W'(req_ready), 0);
                if (rsp_ready) begin
                    in_rsp = 1'b0;
                    rsp_count++;
                end
            end
        end
        prev_rst = rst_n;
        prev_start = core_start & rst_n;
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input int lat, input int stl, input bit wait_rsp);
        int n;
        exp_q.push_back(model(a, b, s));
        core_lat = lat;
        stall = stl;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_dividend = a;
        req_divisor = b;
        req_signed = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_dividend = $urandom;
        req_divisor = $urandom;
        req_signed = 1'($urandom_range(0, 1));
        if (wait_rsp) begin
            sent++;
            n = 0;
            while (rsp_count < sent && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("rsp_timeout", W'(rsp_count), W'(sent));
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_signed = 1'b0;
        req_dividend = '0;
        req_divisor = '0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);

        send(32'd100, 32'd7, 1'b0, 33, 0, 1'b1);
        send(32'hFFFF_FF9C, 32'd7, 1'b1, 5, 0, 1'b1);
        send(32'h0000_1234, 32'd0, 1'b0, 5, 0, 1'b1);
        send(MINV, 32'hFFFF_FFFF, 1'b1, 5, 0, 1'b1);
        send(32'd1000, 32'd3, 1'b0, 4, 10, 1'b1);
        send(32'h0000_1234, 32'd0, 1'b1, 4, 10, 1'b1);

        // Reset while the core is busy; its late core_done must be ignored.
        send(32'd5000, 32'd3, 1'b0, 33, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (core_busy && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'd0 - 32'($urandom_range(1, 15));
                3: begin a = MINV; b = '1; end
                default: ;
            endcase
            send(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(1, 20)),
                 int'($urandom_range(0, 3)), 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
